sd_buffer_ctrl: RTL and testbench

Sequencer and arbiter for the 4096-bit SD sector buffer. It grants one of two requesters (0: cache refill path, 1: boot loader) the buffer for a whole sector. It accepts that requester's 32-bit words over a valid/ready stream and drives the buffer's word address, write-enable and data. Each word is completed on the buffer's write-end pulse, and the block reports sector completion or abort.

---
 rtl/sd_pkg.sv | 17 +
 rtl/sd_buffer_ctrl_if.sv | 34 +++
 rtl/sd_rr_arb2.sv | 21 ++
 rtl/sd_buffer_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sd_buffer_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_pkg.sv
// Shared constants and controller state encoding for the SD sector buffer.
package sd_pkg;

   localparam int SD_SECTOR_BITS = 4096;
   localparam int SD_WORDS       = SD_SECTOR_BITS / 32;
   localparam int SD_WORD_AW     = $clog2(SD_WORDS);

   typedef enum logic [2:0] {
      IDLE,
      ARB,
      WAIT_WORD,
      ISSUE,
      WAIT_END,
      DONE
   } sd_ctrl_state_t;

endpackage

// File: rtl/sd_buffer_ctrl_if.sv
// Requester stream, buffer write port and status bundle of sd_buffer_ctrl.
interface sd_buffer_ctrl_if #(
   parameter int AW = 7
);

   logic [1:0]    req;
   logic [1:0]    gnt;
   logic [1:0]    wvalid;
   logic [31:0]   wdata0;
   logic [31:0]   wdata1;
   logic          wready;
   logic [AW-1:0] buf_addr;
   logic          buf_we;
   logic [31:0]   buf_wdata;
   logic          buf_write_end;
   logic          sector_done;
   logic          abort;
   logic          owner;
   logic [AW:0]   word_cnt;
   logic          busy;

   modport master (
      output req, wvalid, wdata0, wdata1, buf_write_end,
      input  gnt, wready, buf_addr, buf_we, buf_wdata,
      input  sector_done, abort, owner, word_cnt, busy
   );

   modport slave (
      input  req, wvalid, wdata0, wdata1, buf_write_end,
      output gnt, wready, buf_addr, buf_we, buf_wdata,
      output sector_done, abort, owner, word_cnt, busy
   );

endinterface

// File: rtl/sd_rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester that did not own last wins.
module sd_rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_owner,
   output logic [1:0] gnt,
   output logic       idx
);

   always_comb begin
      idx = last_owner;
      case (req)
         2'b01:   idx = 1'b0;
         2'b10:   idx = 1'b1;
         2'b11:   idx = ~last_owner;
         default: idx = last_owner;
      endcase
      gnt = 2'b00;
      if (|req) gnt[idx] = 1'b1;
   end

endmodule

// File: rtl/sd_buffer_ctrl.sv
// Sector-granular arbiter/sequencer writing requester words into the SD sector buffer.
// Optional write-end watchdog and sticky err output: SD_BUFFER_CTRL_TIMEOUT_EN.
module sd_buffer_ctrl
   import sd_pkg::*;
#(
   parameter int WORDS  = SD_WORDS,
   parameter int AW     = SD_WORD_AW,
   parameter int TO_CYC = 15
) (
   input  logic clk,
   input  logic reset_n,
`ifdef SD_BUFFER_CTRL_TIMEOUT_EN
   output logic err,
`endif
   sd_buffer_ctrl_if.slave bus
);

   localparam logic [AW:0] LAST_IDX = (AW+1)'(WORDS - 1);

   sd_ctrl_state_t state, state_nxt;

   logic [1:0]    gnt_q, arb_gnt;
   logic          owner_q, arb_idx;
   logic [AW:0]   cnt_q;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;

   logic          own_req, own_valid;
   logic [31:0]   own_data;
   logic          grant, hs, wr_done, to_hit;
   logic          wready_c, we_c, done_c, abort_c;

   assign own_req   = bus.req[owner_q];
   assign own_valid = bus.wvalid[owner_q];
   assign own_data  = owner_q ? bus.wdata1 : bus.wdata0;

   sd_rr_arb2 u_arb (
      .req        (bus.req),
      .last_owner (owner_q),
      .gnt        (arb_gnt),
      .idx        (arb_idx)
   );

`ifdef SD_BUFFER_CTRL_TIMEOUT_EN
   localparam logic [3:0] TO_LIM = 4'(TO_CYC);
   logic [3:0] to_cnt;

   // Counter is 1 in the first WAIT_END cycle, so the abort lands TO_CYC cycles after buf_we.
   assign to_hit = (state == WAIT_END) && !bus.buf_write_end && (to_cnt == TO_LIM);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         to_cnt <= '0;
         err    <= 1'b0;
      end else begin
         if (state == ISSUE)
            to_cnt <= 4'd1;
         else if (state == WAIT_END && to_cnt != 4'hF)
            to_cnt <= to_cnt + 4'd1;
         if (grant)
            err <= 1'b0;
         else if (to_hit)
            err <= 1'b1;
      end
   end
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      wready_c  = 1'b0;
      we_c      = 1'b0;
      done_c    = 1'b0;
      abort_c   = 1'b0;
      grant     = 1'b0;
      hs        = 1'b0;
      wr_done   = 1'b0;
      case (state)
         IDLE:      if (|bus.req) state_nxt = ARB;
         ARB: begin
            if (|arb_gnt) begin
               grant     = 1'b1;
               state_nxt = WAIT_WORD;
            end else begin
               state_nxt = IDLE;
            end
         end
         WAIT_WORD: begin
            // A dropped request wins over a same-cycle word so nothing is half-accepted.
            if (!own_req) begin
               abort_c   = 1'b1;
               state_nxt = IDLE;
            end else begin
               wready_c = 1'b1;
               if (own_valid) begin
                  hs        = 1'b1;
                  state_nxt = ISSUE;
               end
            end
         end
         ISSUE: begin
            we_c      = 1'b1;
            state_nxt = WAIT_END;
         end
         WAIT_END: begin
            if (bus.buf_write_end) begin
               wr_done   = 1'b1;
               state_nxt = (cnt_q == LAST_IDX) ? DONE : WAIT_WORD;
            end else if (to_hit) begin
               abort_c   = 1'b1;
               state_nxt = IDLE;
            end
         end
         DONE: begin
            done_c    = 1'b1;
            state_nxt = IDLE;
         end
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gnt_q   <= '0;
         owner_q <= 1'b1;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         if (grant) begin
            gnt_q   <= arb_gnt;
            owner_q <= arb_idx;
            cnt_q   <= '0;
         end else if (state_nxt == IDLE) begin
            gnt_q   <= '0;
         end
         // Address/data stay put until the next handshake, covering ISSUE through write-end.
         if (hs) begin
            addr_q  <= cnt_q[AW-1:0];
            wdata_q <= own_data;
         end
         if (wr_done) cnt_q <= cnt_q + 1'b1;
      end
   end

   assign bus.gnt         = gnt_q;
   assign bus.wready      = wready_c;
   assign bus.buf_addr    = addr_q;
   assign bus.buf_we      = we_c;
   assign bus.buf_wdata   = wdata_q;
   assign bus.sector_done = done_c;
   assign bus.abort       = abort_c;
   assign bus.owner       = owner_q;
   assign bus.word_cnt    = cnt_q;
   assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_sd_buffer_ctrl.sv
// Random-stimulus bench for sd_buffer_ctrl with a scoreboard and 2-cycle buffer model.
module tb_sd_buffer_ctrl;

   localparam int WORDS = 128;
   localparam int AW    = 7;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   sd_buffer_ctrl_if #(.AW(AW)) bus ();
`ifdef SD_BUFFER_CTRL_TIMEOUT_EN
   logic err;
`endif

   sd_buffer_ctrl #(.WORDS(WORDS), .AW(AW), .TO_CYC(15)) dut (
      .clk     (clk),
      .reset_n (reset_n),
`ifdef SD_BUFFER_CTRL_TIMEOUT_EN
      .err     (err),
`endif
      .bus     (bus)
   );

   int n_chk, n_fail, cyc;
   int vrate, d_next [2];
   logic [31:0] base [2];
   logic [31:0] exp_q [$];
   int own_seq [$];
   bit pend, wend_now, hold_en, we_prev, last_own, exp_own;
   int we_cyc, hold_addr, words_done, sec_we, drop_at, first_addr;
   int gnt_cyc, done_cyc, abort_cyc, n_done, n_abort, n_grant, req_cyc;
   logic [AW-1:0] cur_addr;
   logic [31:0] cur_data;
   logic [1:0] gnt_prev;
   logic [AW:0] abort_wc, done_wc;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Round-robin rule: contention goes to the non-last owner, a lone request always wins.
   function automatic bit rr_pick(input logic [1:0] r, input bit last);
      if (r == 2'b11) return !last;
      return r[1];
   endfunction

   task automatic clear_model();
      pend = 0; wend_now = 0; hold_en = 0; we_prev = 0;
      exp_q.delete();
      drop_at = -1; n_done = 0; n_abort = 0; words_done = 0; sec_we = 0;
      bus.buf_write_end = 1'b0;
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "_gnt"}, bus.gnt, 0);
      chk({tag, "_wready"}, bus.wready, 0);
      chk({tag, "_we"}, bus.buf_we, 0);
      chk({tag, "_addr"}, bus.buf_addr, 0);
      chk({tag, "_wdata"}, bus.buf_wdata, 0);
      chk({tag, "_done"}, bus.sector_done, 0);
      chk({tag, "_abort"}, bus.abort, 0);
      chk({tag, "_wc"}, bus.word_cnt, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_owner"}, bus.owner, 1);
`ifdef SD_BUFFER_CTRL_TIMEOUT_EN
      chk({tag, "_err"}, err, 0);
`endif
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      bus.req = 2'b00; bus.wvalid = 2'b00;
      bus.wdata0 = '0; bus.wdata1 = '0;
      repeat (2) @(posedge clk);
      #1;
      cyc++;
      chk_rst("rst");
      reset_n = 1'b1;
      clear_model();
      last_own = 1'b1;
      gnt_prev = 2'b00;
   endtask

   // One cycle: drive inputs #1 after the edge, sample outputs #2 after it.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      wend_now = 0;
      bus.buf_write_end = 1'b0;
      if (pend && cyc == we_cyc + 2 && !(hold_en && int'(cur_addr) == hold_addr)) begin
         bus.buf_write_end = 1'b1;
         pend = 0; wend_now = 1; words_done++;
      end
      if (drop_at >= 0 && words_done == drop_at && !pend) bus.req[exp_own] = 1'b0;
      for (int i = 0; i < 2; i++) bus.wvalid[i] = ($urandom_range(99) < vrate);
      bus.wdata0 = base[0] + 32'(d_next[0]);
      bus.wdata1 = base[1] + 32'(d_next[1]);
      #1;
      if (bus.gnt != 2'b00 && gnt_prev == 2'b00) begin
         bit w;
         w = rr_pick(bus.req, last_own);
         chk("grant_onehot", bus.gnt, 64'd1 << w);
         chk("grant_owner", bus.owner, w);
         chk("grant_wc", bus.word_cnt, 0);
         exp_own = w; last_own = w; own_seq.push_back(int'(w));
         n_grant++; gnt_cyc = cyc; sec_we = 0; words_done = 0;
      end
      gnt_prev = bus.gnt;
      if (bus.buf_we) begin
         chk("we_single", we_prev, 0);
         chk("we_addr", bus.buf_addr, sec_we);
         if (exp_q.size() == 0) chk("we_no_word", 1, 0);
         else chk("we_data", bus.buf_wdata, exp_q.pop_front());
         if (sec_we == 0) first_addr = int'(bus.buf_addr);
         cur_addr = bus.buf_addr; cur_data = bus.buf_wdata;
         pend = 1; we_cyc = cyc; sec_we++;
      end else if (pend || wend_now) begin
         chk("hold_addr", bus.buf_addr, cur_addr);
         chk("hold_data", bus.buf_wdata, cur_data);
      end
      we_prev = bus.buf_we;
      if (bus.wready && bus.wvalid[exp_own]) begin
         exp_q.push_back(exp_own ? bus.wdata1 : bus.wdata0);
         d_next[exp_own]++;
      end
      if (bus.sector_done) begin n_done++; done_cyc = cyc; done_wc = bus.word_cnt; end
      if (bus.abort) begin n_abort++; abort_cyc = cyc; abort_wc = bus.word_cnt; end
   endtask

   initial begin
      n_chk = 0; n_fail = 0; cyc = 0; n_grant = 0;
      vrate = 100; d_next[0] = 0; d_next[1] = 0; base[0] = 0; base[1] = 0;
      bus.buf_write_end = 1'b0;
      apply_reset();

      // Sector from requester 0 only, full-rate words 0..127.
      base[1] = $urandom; d_next[0] = 0;
      bus.req = 2'b01; req_cyc = cyc;
      for (int k = 0; k < 700 && n_done == 0; k++) begin
         step();
         if (cyc == req_cyc + 2) chk("t1_wready", bus.wready, 1);
      end
      chk("t1_done", n_done, 1);
      chk("t1_lat", gnt_cyc - req_cyc, 2);
      chk("t1_len", done_cyc - gnt_cyc, 4 * WORDS);
      chk("t1_we_cnt", sec_we, WORDS);
      chk("t1_done_wc", done_wc, WORDS);
      chk("t1_abort", n_abort, 0);
      bus.req = 2'b00;
      step(); step();
      chk("t1_idle_busy", bus.busy, 0);
      chk("t1_idle_gnt", bus.gnt, 0);

      // Both requesting from reset, random valid: three sectors alternate 0,1,0.
      apply_reset();
      own_seq.delete();
      base[0] = $urandom; base[1] = $urandom; vrate = 70;
      bus.req = 2'b11;
      for (int k = 0; k < 5000 && n_done < 3; k++) begin
         step();
         if (n_done == 3) bus.req = 2'b00;
      end
      chk("t2_done", n_done, 3);
      chk("t2_ngrant", own_seq.size(), 3);
      if (own_seq.size() == 3) begin
         chk("t2_own0", own_seq[0], 0);
         chk("t2_own1", own_seq[1], 1);
         chk("t2_own2", own_seq[2], 0);
      end
      step();

      // Requester 1 alone (last owner was 0) drops its request after 5 words.
      clear_model();
      vrate = 60; drop_at = 5;
      bus.req = 2'b10;
      for (int k = 0; k < 300 && n_abort == 0; k++) step();
      chk("t3_abort", n_abort, 1);
      chk("t3_wc", abort_wc, 5);
      chk("t3_owner", exp_own, 1);
      chk("t3_nodone", n_done, 0);
      step();
      chk("t3_gnt", bus.gnt, 0);
      chk("t3_busy", bus.busy, 0);

      // Asynchronous reset while word 60 is in flight, then a clean restart.
      clear_model();
      vrate = 80;
      bus.req = 2'b01;
      for (int k = 0; k < 1000 && !(words_done == 60 && pend); k++) step();
      chk("t4_reached", words_done, 60);
      #2 reset_n = 1'b0;
      #1 chk_rst("t4_async");
      @(posedge clk);
      #1 cyc++;
      reset_n = 1'b1;
      clear_model(); last_own = 1'b1; gnt_prev = 2'b00; first_addr = -1;
      for (int k = 0; k < 1500 && n_done == 0; k++) begin
         step();
         if (n_done == 1) bus.req = 2'b00;
      end
      chk("t4_done", n_done, 1);
      chk("t4_abort", n_abort, 0);
      chk("t4_first", first_addr, 0);
      step();

      // Buffer never completes word 3.
      clear_model();
      vrate = 100; hold_en = 1; hold_addr = 3;
      bus.req = 2'b01;
`ifdef SD_BUFFER_CTRL_TIMEOUT_EN
      for (int k = 0; k < 150 && n_abort == 0; k++) step();
      chk("t5_abort", n_abort, 1);
      chk("t5_to_lat", abort_cyc - we_cyc, 15);
      chk("t5_wc", abort_wc, 3);
      clear_model();
      step();
      chk("t5_err", err, 1);
      chk("t5_gnt", bus.gnt, 0);
      begin
         int g0;
         g0 = n_grant;
         for (int k = 0; k < 10 && n_grant == g0; k++) step();
         chk("t5_regrant", n_grant - g0, 1);
         chk("t5_err_clr", err, 0);
      end
      bus.req = 2'b00;
      for (int k = 0; k < 40 && n_abort == 0; k++) step();
      chk("t5_abort2", n_abort, 1);
`else
      for (int k = 0; k < 60; k++) step();
      chk("t5_noabort", n_abort, 0);
      chk("t5_busy", bus.busy, 1);
      chk("t5_wc", bus.word_cnt, 3);
      chk("t5_nodone", n_done, 0);
      chk("t5_addr", bus.buf_addr, 3);
      apply_reset();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
